// File: rtl/op_seq_pkg.sv
// Shared types and constants for the operator request sequencer and its consumers.
package op_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CFG_WR,
        ST_CFG_SETTLE,
        ST_RUN,
        ST_HOLD
    } op_seq_state_e;

    localparam logic [31:0] OP_TYPE_ADDR = 32'd10;
    localparam logic [31:0] OP_ADD_SUB   = 32'd1;   // z = a + b - c
    localparam logic [31:0] OP_SUB_SUB   = 32'd2;   // z = a - b - c

    localparam int RES_SEQ_W = 8;

    typedef struct packed {
        logic [63:0]          data;
        logic [RES_SEQ_W-1:0] seq;
    } op_seq_result_t;

endpackage

// File: rtl/op_seq_timer.sv
// 4-bit loadable down-counter with a zero flag; it saturates at zero.
module op_seq_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic       zero
);

    logic [3:0] cnt_q;
    logic [3:0] cnt_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != 4'd0)) begin
            cnt_d = cnt_q - 4'd1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 4'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == 4'd0);

endmodule

// File: rtl/op_req_sequencer.sv
// Feeds operand triples and config writes to OPERATOR_IP, holds operands for the
// operator latency and returns the captured z with a sequence tag.
module op_req_sequencer
    import op_seq_pkg::*;
#(
    parameter int OP_LAT     = 4,
    parameter int CFG_SETTLE = 2,
    parameter int SEQ_W      = RES_SEQ_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [31:0]      req_c,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [31:0]      cfg_addr,
    input  logic [31:0]      cfg_data,
    output logic [31:0]      a,
    output logic [31:0]      b,
    output logic [31:0]      c,
    output logic             reg_wr,
    output logic [31:0]      reg_addr,
    output logic [31:0]      reg_wr_data,
    input  logic [63:0]      z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic [SEQ_W-1:0] res_seq,
    output logic             busy
);

    // The timer exits on its zero flag, so it is loaded with one less than the cycle count.
    localparam logic [3:0] RUN_LOAD    = 4'(OP_LAT - 1);
    localparam logic [3:0] SETTLE_LOAD = 4'(CFG_SETTLE - 1);

    op_seq_state_e  state_q, state_d;
    logic [31:0]    a_q, a_d, b_q, b_d, c_q, c_d;
    logic           reg_wr_q, reg_wr_d;
    logic [31:0]    reg_addr_q, reg_addr_d, reg_wr_data_q, reg_wr_data_d;
    logic           res_valid_q, res_valid_d;
    op_seq_result_t res_q, res_d;
    logic [SEQ_W-1:0] seq_q, seq_d, tag_q, tag_d;

    logic       tmr_load;
    logic [3:0] tmr_load_val;
    logic       tmr_dec;
    logic       tmr_zero;

    op_seq_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_comb begin
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        c_d           = c_q;
        reg_wr_d      = 1'b0;
        reg_addr_d    = reg_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        res_valid_d   = res_valid_q;
        res_d         = res_q;
        seq_d         = seq_q;
        tag_d         = tag_q;
        tmr_load      = 1'b0;
        tmr_load_val  = 4'd0;
        tmr_dec       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Config wins over a simultaneous request, keeping the op type stable per result.
                if (cfg_valid) begin
                    reg_addr_d    = cfg_addr;
                    reg_wr_data_d = cfg_data;
                    reg_wr_d      = 1'b1;
                    state_d       = ST_CFG_WR;
                end else if (req_valid) begin
                    a_d          = req_a;
                    b_d          = req_b;
                    c_d          = req_c;
                    tag_d        = seq_q;
                    seq_d        = seq_q + SEQ_W'(1);
                    tmr_load     = 1'b1;
                    tmr_load_val = RUN_LOAD;
                    state_d      = ST_RUN;
                end
            end
            ST_CFG_WR: begin
                if (CFG_SETTLE == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    tmr_load     = 1'b1;
                    tmr_load_val = SETTLE_LOAD;
                    state_d      = ST_CFG_SETTLE;
                end
            end
            ST_CFG_SETTLE: begin
                if (tmr_zero) state_d = ST_IDLE;
                else          tmr_dec = 1'b1;
            end
            ST_RUN: begin
                if (tmr_zero) begin
                    res_d.data  = z;
                    res_d.seq   = tag_q;
                    res_valid_d = 1'b1;
                    state_d     = ST_HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            a_q           <= '0;
            b_q           <= '0;
            c_q           <= '0;
            reg_wr_q      <= 1'b0;
            reg_addr_q    <= '0;
            reg_wr_data_q <= '0;
            res_valid_q   <= 1'b0;
            res_q         <= '0;
            seq_q         <= '0;
            tag_q         <= '0;
        end else begin
            state_q       <= state_d;
            a_q           <= a_d;
            b_q           <= b_d;
            c_q           <= c_d;
            reg_wr_q      <= reg_wr_d;
            reg_addr_q    <= reg_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            res_valid_q   <= res_valid_d;
            res_q         <= res_d;
            seq_q         <= seq_d;
            tag_q         <= tag_d;
        end
    end

    assign cfg_ready   = (state_q == ST_IDLE);
    assign req_ready   = (state_q == ST_IDLE) && !cfg_valid;
    assign busy        = (state_q != ST_IDLE);
    assign a           = a_q;
    assign b           = b_q;
    assign c           = c_q;
    assign reg_wr      = reg_wr_q;
    assign reg_addr    = reg_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign res_valid   = res_valid_q;
    assign res_data    = res_q.data;
    assign res_seq     = res_q.seq;

endmodule

// File: tb/tb_op_req_sequencer.sv
// Directed bench for op_req_sequencer: a per-cycle vector table for the basic
// config/compute flow, then hand-written sequences for the multi-cycle corners.
module tb_op_req_sequencer;
    import op_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [31:0] req_a, req_b, req_c;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_addr, cfg_data;
    logic [31:0] a, b, c;
    logic        reg_wr;
    logic [31:0] reg_addr, reg_wr_data;
    logic [63:0] z;
    logic        res_valid, res_ready;
    logic [63:0] res_data;
    logic [7:0]  res_seq;
    logic        busy;

    int n_vec  = 0;
    int n_fail = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    op_req_sequencer #(.OP_LAT(4), .CFG_SETTLE(2), .SEQ_W(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .a(a), .b(b), .c(c),
        .reg_wr(reg_wr), .reg_addr(reg_addr), .reg_wr_data(reg_wr_data),
        .z(z),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_seq(res_seq),
        .busy(busy)
    );

    // Behavioural stand-in for OPERATOR_IP: op-type register plus combinational result.
    logic [31:0] op_type;
    always @(posedge clk or negedge rst) begin
        if (!rst)                                    op_type <= OP_ADD_SUB;
        else if (reg_wr && reg_addr == OP_TYPE_ADDR) op_type <= reg_wr_data;
    end
    always_comb begin
        z = {32'h0, (op_type == OP_SUB_SUB) ? (a - b - c) : (a + b - c)};
    end

    typedef struct {
        logic        cfg_v;
        logic [31:0] cfg_d;
        logic        req_v;
        logic        cr, qr, rw, bz, rv;
        logic [31:0] ea;
        logic [63:0] ed;
        logic [7:0]  es;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input int cfg_v, input int cfg_d, input int req_v,
                                input int cr, input int qr, input int rw, input int bz,
                                input int rv, input int ea, input int ed, input int es);
        vec_t v;
        v.cfg_v = 1'(cfg_v); v.cfg_d = 32'(cfg_d); v.req_v = 1'(req_v);
        v.cr = 1'(cr); v.qr = 1'(qr); v.rw = 1'(rw); v.bz = 1'(bz); v.rv = 1'(rv);
        v.ea = 32'(ea); v.ed = 64'(ed); v.es = 8'(es);
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; req_valid = 1'b0; cfg_valid = 1'b0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, last;
        bit seen;

        req_valid = 1'b0; cfg_valid = 1'b0; res_ready = 1'b0;
        req_a = '0; req_b = '0; req_c = '0;
        cfg_addr = OP_TYPE_ADDR; cfg_data = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();

        check("reset_state",
              {cfg_ready, req_ready, reg_wr, busy, res_valid, a, b, c, reg_addr, reg_wr_data, res_data, res_seq},
              {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 96'd0, 64'd0, 64'd0, 8'd0});

        // Columns: cfg_v cfg_d req_v | cfg_rdy req_rdy reg_wr busy res_valid a res_data res_seq
        vecs.push_back(mk(1, 1, 0,  1, 0, 0, 0, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 1, 1, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 0, 1, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 0, 1, 0,   0,   0, 0));
        vecs.push_back(mk(0, 0, 1,  1, 1, 0, 0, 0,   0,   0, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 100, 0, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 1, 100, 140, 0));
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 100, 140, 0));
        vecs.push_back(mk(1, 2, 0,  1, 0, 0, 0, 0, 100, 140, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 1, 1, 0, 100, 140, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 0, 1, 0, 100, 140, 0));
        vecs.push_back(mk(0, 0, 1,  0, 0, 0, 1, 0, 100, 140, 0));
        vecs.push_back(mk(0, 0, 1,  1, 1, 0, 0, 0, 100, 140, 0));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 0, 100, 140, 0));
        vecs.push_back(mk(0, 0, 0,  0, 0, 0, 1, 1, 100, 40, 1));
        vecs.push_back(mk(0, 0, 0,  1, 1, 0, 0, 0, 100, 40, 1));

        req_a = 32'd100; req_b = 32'd50; req_c = 32'd10; res_ready = 1'b1;
        foreach (vecs[i]) begin
            cfg_valid = vecs[i].cfg_v;
            cfg_data  = vecs[i].cfg_d;
            req_valid = vecs[i].req_v;
            #1;
            check($sformatf("vec%0d", i),
                  {cfg_ready, req_ready, reg_wr, busy, res_valid, a, res_data, res_seq},
                  {vecs[i].cr, vecs[i].qr, vecs[i].rw, vecs[i].bz, vecs[i].rv,
                   vecs[i].ea, vecs[i].ed, vecs[i].es});
            step();
        end
        cfg_valid = 1'b0; req_valid = 1'b0;
        check("cfg_regs_retained", {reg_addr, reg_wr_data}, {32'd10, 32'd2});

        // Backpressure: result held for 20 cycles while a new request waits.
        req_a = 32'd7; req_b = 32'd3; req_c = 32'd1; req_valid = 1'b1; res_ready = 1'b0; #1;
        check("bp_accept", req_ready, 1);
        step();
        for (int k = 0; k < 10 && !res_valid; k++) step();
        for (int k = 0; k < 20; k++) begin
            check($sformatf("bp_hold%0d", k), {res_valid, req_ready, a, b, c, res_data, res_seq},
                  {1'b1, 1'b0, 32'd7, 32'd3, 32'd1, 64'd3, 8'd2});
            step();
        end
        res_ready = 1'b1; req_valid = 1'b0; #1;
        check("bp_release", {res_valid, busy}, 2'b11);
        step();
        check("bp_after_handshake", {res_valid, busy}, 2'b00);
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (res_valid) seen = 1'b1;
            step();
        end
        check("bp_single_handshake", seen, 0);

        // Config and request together: config first, request on first IDLE after settle.
        cfg_data = 32'd1; cfg_valid = 1'b1;
        req_a = 32'd100; req_b = 32'd50; req_c = 32'd10; req_valid = 1'b1; #1;
        check("prio_ready", {cfg_ready, req_ready}, 2'b10);
        step();
        cfg_valid = 1'b0; #1;
        n = 1;
        while (!req_ready && n < 10) begin
            step();
            n++;
        end
        check("prio_accept_cycle", n, 4);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !res_valid; k++) step();
        check("prio_result", {res_valid, res_seq, res_data}, {1'b1, 8'd3, 64'd140});
        step();

        // 257 back-to-back requests: tag wrap and 6-cycle result spacing.
        do_reset();
        res_ready = 1'b1; req_valid = 1'b1; last = 0;
        for (int i = 0; i < 257; i++) begin
            req_a = 32'(i * 3); req_b = 32'(i); req_c = 32'd5; #1;
            for (int k = 0; k < 10 && !req_ready; k++) step();
            check($sformatf("b2b_accept%0d", i), req_ready, 1);
            step();
            for (int k = 0; k < 10 && !res_valid; k++) step();
            check($sformatf("b2b_result%0d", i), {res_valid, res_seq, res_data},
                  {1'b1, 8'(i), 32'h0, 32'(4 * i - 5)});
            if (i > 0) check($sformatf("b2b_spacing%0d", i), cyc - last, 6);
            last = cyc;
        end
        req_valid = 1'b0;
        step();
        step();

        // Asynchronous reset in the middle of RUN.
        cfg_data = 32'd2; cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        for (int k = 0; k < 10 && !req_ready; k++) step();
        req_a = 32'd9; req_b = 32'd8; req_c = 32'd7; req_valid = 1'b1; #1;
        check("ar_accept", req_ready, 1);
        step();
        req_valid = 1'b0;
        step();
        check("ar_in_run", {busy, a, reg_addr}, {1'b1, 32'd9, 32'd10});
        #3 rst = 1'b0;
        #1;
        check("ar_async_clear",
              {a, b, c, reg_wr, reg_addr, reg_wr_data, res_valid, res_data, res_seq, busy}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        step();
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (res_valid) seen = 1'b1;
            step();
        end
        check("ar_no_stale_result", seen, 0);
        req_valid = 1'b1; #1;
        check("ar_ready_after", req_ready, 1);
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 10 && !res_valid; k++) step();
        check("ar_first_result", {res_valid, res_seq, res_data}, {1'b1, 8'd0, 64'd10});
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/op_req_sequencer.md
Name: op_req_sequencer

Overview:
- Upstream feeder for OPERATOR_IP.
- Accepts operand triples and op-type configuration writes over valid/ready interfaces, then drives the operator's a/b/c and register-write ports.
- Holds operands stable for the operator latency, captures z and returns it with a sequence tag over a valid/ready result interface.
- Configuration writes are serialised against computations, so the op type never changes while a result is in flight.

Parameters:
- OP_LAT, 4: cycles a/b/c are held before z is sampled; legal range 1..15.
- CFG_SETTLE, 2: idle cycles after a register write before the next request is accepted; legal range 0..15.
- SEQ_W, 8: width of the result sequence tag.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low (asserted at 0).
- req_valid  in  1  operand request valid.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_a, req_b, req_c  in  32 each  operands.
- cfg_valid  in  1  config write request.
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready.
- cfg_addr, cfg_data  in  32 each  register address and data.
- a, b, c  out  32 each  to operator.
- reg_wr  out  1  to operator; single-cycle pulse.
- reg_addr, reg_wr_data  out  32 each  to operator.
- z  in  64  operator result.
- res_valid  out  1  result valid.
- res_ready  in  1  result accepted when res_valid && res_ready.
- res_data  out  64  captured z.
- res_seq  out  SEQ_W  tag of the request that produced res_data.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - All registered outputs go to 0: a, b, c, reg_wr, reg_addr, reg_wr_data, res_valid, res_data, res_seq.
  - Sequence counter goes to 0 and state goes to IDLE.
  - Any in-flight request or result is dropped.
- States: IDLE, CFG_WR, CFG_SETTLE, RUN, HOLD.
- Ready outputs are combinational from state and inputs:
  - cfg_ready = (state==IDLE).
  - req_ready = (state==IDLE) && !cfg_valid.
  - Config has strict priority over requests when both are valid.
- IDLE + cfg accept:
  - Register cfg_addr/cfg_data onto reg_addr/reg_wr_data and set reg_wr=1 the next cycle.
  - Go to CFG_WR.
- CFG_WR (exactly 1 cycle):
  - reg_wr=1, then cleared.
  - reg_addr/reg_wr_data retain their values afterwards.
  - Go to CFG_SETTLE with counter=CFG_SETTLE; if CFG_SETTLE=0, go directly to IDLE.
- CFG_SETTLE: decrement the counter each cycle; when it reaches 0, go to IDLE.
- IDLE + req accept at cycle T:
  - a/b/c take req_a/b/c at T+1.
  - Tag = seq counter, which then increments modulo 2^SEQ_W (255 wraps to 0).
  - Go to RUN with counter=OP_LAT.
- RUN:
  - a/b/c held constant.
  - Counter decrements each cycle.
  - z is sampled on the edge ending cycle T+OP_LAT into res_data; res_seq is loaded with the tag.
  - res_valid=1 from T+OP_LAT+1; go to HOLD.
  - Accept-to-res_valid latency = OP_LAT+1 cycles.
- HOLD:
  - res_valid, res_data and res_seq stay stable until res_ready=1.
  - On handshake: res_valid=0 next cycle, go to IDLE.
  - No new request is accepted in the handshake cycle. Peak throughput is one result per OP_LAT+2 cycles.
- After completion a/b/c retain their last values; they are not zeroed.
- res_ready asserted while res_valid=0: ignored.
- z is only sampled in the final RUN cycle; its values at other times are don't-care.
- Width: res_data = z unmodified, 64-bit; no sign handling in this block.
- Illegal states decode to IDLE.

Decomposition:
- Package op_seq_pkg:
  - state enum op_seq_state_e.
  - OP_TYPE_ADDR = 10.
  - Op codes OP_ADD_SUB = 1 (a+b-c) and OP_SUB_SUB = 2 (a-b-c).
  - Result struct {data[63:0], seq}.
- Sub-module op_seq_timer: a 4-bit loadable down-counter with a zero flag, shared by RUN and CFG_SETTLE.

Test Plan:
1. Reset, then cfg (addr 10, data 1), then req a=100, b=50, c=10 with res_ready=1:
   - reg_wr pulses exactly 1 cycle.
   - res_valid rises 5 cycles after accept.
   - res_data=140, res_seq=0.
2. cfg (addr 10, data 2), then req 100/50/10:
   - res_data=40, res_seq=1.
   - req_ready stays 0 through CFG_WR plus 2 settle cycles.
3. Backpressure: hold res_ready=0 for 20 cycles:
   - res_valid stays 1 with res_data stable.
   - req_ready=0 and a/b/c unchanged.
   - Releasing res_ready gives exactly one handshake; busy drops the next cycle.
4. cfg_valid and req_valid both asserted in IDLE:
   - Config is taken first and the request is stalled.
   - The request is accepted on the first IDLE cycle after the settle period and computes with the new op type.
5. 257 back-to-back requests with res_ready=1:
   - res_seq runs 0..255 then 0.
   - Spacing between res_valid pulses = 6 cycles.
6. Drive rst=0 asynchronously mid-RUN:
   - Outputs clear immediately and res_valid never asserts for that request.
   - After release, req_ready=1 and the next result carries res_seq=0.
